// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the static-pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  // Polarity constants shared across the pipeline RTL
  localparam logic RST_ENABLED   = 1'b1;
  localparam logic STOP          = 1'b1;
  localparam logic WRITE_ENABLED = 1'b1;

  // Register-file addressing and multi-cycle counter widths
  localparam int            REG_ADDR_W = 5;
  localparam logic [4:0]    REG_ZERO   = 5'd0;
  localparam int            MCNT_W     = 8;

  // One in-flight register-file write tracked downstream of ID
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] waddr;
  } sb_entry_t;

  // True when a source operand that is actually read hits a pending write
  function automatic logic reg_match(sb_entry_t e, logic used,
                                     logic [REG_ADDR_W-1:0] addr);
    return used && (addr != REG_ZERO) && e.valid && (e.waddr == addr);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage to hazard-controller bundle: decoded operand info in, pipeline enables out.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       id_rs_addr;
  logic             id_rs_used;
  logic [4:0]       id_rt_addr;
  logic             id_rt_used;
  logic [4:0]       id_rf_waddr;
  logic             id_rf_wena;
  logic             id_multi;
  logic             id_hilo_read;
  logic             stall;
  logic             pc_wena;
  logic             if_id_wena;
  logic             id_exe_wena;
  logic             multi_busy;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
           id_rf_waddr, id_rf_wena, id_multi, id_hilo_read,
    input  stall, pc_wena, if_id_wena, id_exe_wena, multi_busy, stall_cycles
  );

  modport slave (
    input  id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
           id_rf_waddr, id_rf_wena, id_multi, id_hilo_read,
    output stall, pc_wena, if_id_wena, id_exe_wena, multi_busy, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Shift scoreboard mirroring EXE..WB; flags a RAW hazard for the ID operands.
module hazard_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int SB_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  wr_valid,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic                  rs_used,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic                  rt_used,
  output logic                  raw_hazard
);

  sb_entry_t [SB_DEPTH-1:0] entries;

  // Advance every tracked write one stage; EXE gets the issuing write or a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLED) begin
      entries <= '0;
    end else begin
      if (stall == STOP) begin
        entries[0] <= '0;
      end else begin
        entries[0] <= {wr_valid && (wr_addr != REG_ZERO), wr_addr};
      end
      for (int i = 1; i < SB_DEPTH; i++) begin
        entries[i] <= entries[i-1];
      end
    end
  end

  // Any valid downstream write to a register the ID instruction reads blocks issue
  always_comb begin
    raw_hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (reg_match(entries[i], rs_used, rs_addr) ||
          reg_match(entries[i], rt_used, rt_addr)) begin
        raw_hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall controller for the no-forwarding pipeline: RAW scoreboard plus mult/div occupancy.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int SB_DEPTH     = 3,
  parameter int MULTI_CYCLES = 8,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  logic              raw_hazard;
  logic              struct_hazard;
  logic              stall_int;
  logic              busy;
  logic [MCNT_W-1:0] mcnt;
  logic [CNT_W-1:0]  stall_cnt;

  hazard_scoreboard #(.SB_DEPTH(SB_DEPTH)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall_int),
    .wr_valid   (bus.id_rf_wena == WRITE_ENABLED),
    .wr_addr    (bus.id_rf_waddr),
    .rs_addr    (bus.id_rs_addr),
    .rs_used    (bus.id_rs_used),
    .rt_addr    (bus.id_rt_addr),
    .rt_used    (bus.id_rt_used),
    .raw_hazard (raw_hazard)
  );

  // Issue decision; all enables drop while reset is held
  always_comb begin
    busy             = (mcnt != '0);
    struct_hazard    = busy && (bus.id_multi || bus.id_hilo_read);
    stall_int        = (raw_hazard || struct_hazard) ? STOP : ~STOP;
    bus.stall        = stall_int && !rst;
    bus.pc_wena      = !stall_int && !rst;
    bus.if_id_wena   = !stall_int && !rst;
    bus.id_exe_wena  = !rst;
    bus.multi_busy   = busy;
    bus.stall_cycles = stall_cnt;
  end

  // Mult/div occupancy: load on issue, otherwise count down to idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLED) begin
      mcnt <= '0;
    end else if (bus.id_multi && (stall_int != STOP)) begin
      mcnt <= MCNT_W'(MULTI_CYCLES - 1);
    end else if (mcnt != '0) begin
      mcnt <= mcnt - 1'b1;
    end
  end

  // Saturating count of cycles in which ID was held
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLED) begin
      stall_cnt <= '0;
    end else if ((stall_int == STOP) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed bench for pipe_hazard_ctrl against a timestamp-based model.
module tb_pipe_hazard_ctrl;

  localparam int SB_DEPTH     = 3;
  localparam int MULTI_CYCLES = 8;
  localparam int CNT_W        = 16;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .SB_DEPTH     (SB_DEPTH),
    .MULTI_CYCLES (MULTI_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Model state: each issued write is remembered with the edge number that issued it
  int now        = 0;
  int wr_reg[$];
  int wr_edge[$];
  int last_multi = -100000;
  int model_cnt  = 0;
  int stall_total = 0;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit modelRaw(int rs, bit rsu, int rt, bit rtu);
    bit hit = 1'b0;
    foreach (wr_reg[i]) begin
      if (now - wr_edge[i] < SB_DEPTH) begin
        if (rsu && rs != 0 && rs == wr_reg[i]) hit = 1'b1;
        if (rtu && rt != 0 && rt == wr_reg[i]) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  function automatic bit modelBusy();
    return (now - last_multi) < (MULTI_CYCLES - 1);
  endfunction

  task automatic modelClear();
    wr_reg.delete();
    wr_edge.delete();
    last_multi = -100000;
    model_cnt  = 0;
  endtask

  // Drive one ID instruction for one cycle, check outputs mid-cycle, advance the model
  task automatic applyStimulus(input int rs, input bit rsu, input int rt, input bit rtu,
                               input int wd, input bit we, input bit multi, input bit hilo);
    bit exp_stall;
    bus.id_rs_addr   = 5'(rs);
    bus.id_rs_used   = rsu;
    bus.id_rt_addr   = 5'(rt);
    bus.id_rt_used   = rtu;
    bus.id_rf_waddr  = 5'(wd);
    bus.id_rf_wena   = we;
    bus.id_multi     = multi;
    bus.id_hilo_read = hilo;
    @(negedge clk);
    exp_stall = modelRaw(rs, rsu, rt, rtu) || (modelBusy() && (multi || hilo));
    checkOutput("stall",        32'(bus.stall),        32'(exp_stall));
    checkOutput("pc_wena",      32'(bus.pc_wena),      32'(!exp_stall));
    checkOutput("if_id_wena",   32'(bus.if_id_wena),   32'(!exp_stall));
    checkOutput("id_exe_wena",  32'(bus.id_exe_wena),  32'd1);
    checkOutput("multi_busy",   32'(bus.multi_busy),   32'(modelBusy()));
    checkOutput("stall_cycles", 32'(bus.stall_cycles), 32'(model_cnt));
    @(posedge clk);
    if (exp_stall) begin
      stall_total++;
      if (model_cnt < CNT_MAX) model_cnt++;
    end else begin
      if (we && wd != 0) begin
        wr_reg.push_back(wd);
        wr_edge.push_back(now + 1);
      end
      if (multi) last_multi = now + 1;
    end
    now++;
    while (wr_edge.size() > 0 && now - wr_edge[0] >= SB_DEPTH) begin
      void'(wr_reg.pop_front());
      void'(wr_edge.pop_front());
    end
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_stall"},   32'(bus.stall),        32'd0);
    checkOutput({tag, "_pc"},      32'(bus.pc_wena),      32'd0);
    checkOutput({tag, "_ifid"},    32'(bus.if_id_wena),   32'd0);
    checkOutput({tag, "_idexe"},   32'(bus.id_exe_wena),  32'd0);
    checkOutput({tag, "_busy"},    32'(bus.multi_busy),   32'd0);
    checkOutput({tag, "_cnt"},     32'(bus.stall_cycles), 32'd0);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic pulseReset(input string tag);
    rst = 1'b1;
    #1;
    checkResetValues(tag);
    modelClear();
    #1;
    rst = 1'b0;
  endtask

  task automatic nop();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.id_rs_addr = '0; bus.id_rs_used = 0; bus.id_rt_addr = '0; bus.id_rt_used = 0;
    bus.id_rf_waddr = '0; bus.id_rf_wena = 0; bus.id_multi = 0; bus.id_hilo_read = 0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("por");
    rst = 1'b0;

    $display("[TB] independent instructions");
    for (int i = 1; i <= 5; i++) applyStimulus(6, 1, 7, 1, i, 1, 0, 0);
    checkOutput("indep_cnt", 32'(bus.stall_cycles), 32'd0);

    $display("[TB] add r3 / sub r4,r3");
    pulseReset("r1");
    applyStimulus(1, 1, 2, 1, 3, 1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(3, 1, 5, 1, 4, 1, 0, 0);
    checkOutput("raw_cnt", 32'(bus.stall_cycles), 32'd3);

    $display("[TB] r0 writer/reader");
    pulseReset("r2");
    applyStimulus(1, 1, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 1, 2, 1, 0, 0);
    checkOutput("r0_stall", 32'(bus.stall), 32'd0);

    $display("[TB] div / add / mflo");
    pulseReset("r3");
    applyStimulus(1, 1, 2, 1, 0, 0, 1, 0);
    applyStimulus(5, 1, 6, 1, 7, 1, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 0, 8, 1, 0, 1);
    checkOutput("div_cnt", 32'(bus.stall_cycles), 32'd6);
    nop();

    $display("[TB] rt hazard with mult");
    pulseReset("r4");
    applyStimulus(0, 0, 0, 0, 5, 1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 5, 1, 0, 0, 1, 0);
    checkOutput("mult_busy_after", 32'(bus.multi_busy), 32'd1);

    $display("[TB] reset mid-multi");
    pulseReset("r5");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 2, 1, 0, 0);
    pulseReset("r6");
    applyStimulus(2, 1, 1, 1, 3, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    $display("[TB] random traffic");
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) pulseReset("rr");
      applyStimulus($urandom_range(0, 7), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end

    $display("[TB] counter saturation");
    pulseReset("r7");
    stall_total = 0;
    for (int n = 0; n < 85000 && stall_total < 70000; n++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    end
    checkOutput("sat_reached", 32'(stall_total >= 70000), 32'd1);
    checkOutput("sat_value", 32'(bus.stall_cycles), 32'(CNT_MAX));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
